// File: rtl/cache_set_assoc_if.sv
// Request/response, writeback and fill buses of one cache set.
// slave: the cache set. master: requester plus next memory level.
interface cache_set_assoc_if #(
  parameter int BLOCK_BYTES = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int TAG_WIDTH   = 8
);
  localparam int OFFSET_WIDTH = $clog2(BLOCK_BYTES);
  localparam int SIZE_WIDTH   = $clog2(DATA_WIDTH/8) + 1;
  localparam int LINE_WIDTH   = 8*BLOCK_BYTES;

  logic                    req_valid_in;
  logic                    req_ready_out;
  logic                    req_write_in;
  logic [TAG_WIDTH-1:0]    tag_in;
  logic [OFFSET_WIDTH-1:0] offset_in;
  logic [SIZE_WIDTH-1:0]   data_size_in;
  logic [DATA_WIDTH-1:0]   data_in;
  logic                    resp_valid_out;
  logic                    hit_out;
  logic                    error_out;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    evict_valid_out;
  logic                    evict_ready_in;
  logic [TAG_WIDTH-1:0]    evict_tag_out;
  logic [LINE_WIDTH-1:0]   evict_data_out;
  logic                    fill_req_valid_out;
  logic [TAG_WIDTH-1:0]    fill_tag_out;
  logic                    fill_valid_in;
  logic [LINE_WIDTH-1:0]   fill_data_in;

  modport slave (
    input  req_valid_in, req_write_in, tag_in,
    input  offset_in, data_size_in, data_in,
    input  evict_ready_in, fill_valid_in, fill_data_in,
    output req_ready_out, resp_valid_out, hit_out,
    output error_out, data_out,
    output evict_valid_out, evict_tag_out, evict_data_out,
    output fill_req_valid_out, fill_tag_out
  );

  modport master (
    output req_valid_in, req_write_in, tag_in,
    output offset_in, data_size_in, data_in,
    output evict_ready_in, fill_valid_in, fill_data_in,
    input  req_ready_out, resp_valid_out, hit_out,
    input  error_out, data_out,
    input  evict_valid_out, evict_tag_out, evict_data_out,
    input  fill_req_valid_out, fill_tag_out
  );
endinterface

// File: rtl/cache_set_assoc.sv
// N-way set-associative cache set, LRU, write-back, write-allocate.
// Ports: clock_signal, reset_signal (async high), bus (slave modport).
module cache_set_assoc #(
  parameter int NUM_WAYS    = 2,
  parameter int BLOCK_BYTES = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int TAG_WIDTH   = 8
) (
  input logic clock_signal,
  input logic reset_signal,
  cache_set_assoc_if.slave bus
);
  localparam int DB = DATA_WIDTH/8;
  localparam int OW = $clog2(BLOCK_BYTES);
  localparam int SW = $clog2(DB) + 1;
  localparam int AW = $clog2(NUM_WAYS);
  localparam int LW = 8*BLOCK_BYTES;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, EVICT, FILL, RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [TAG_WIDTH-1:0]   r_tag   [NUM_WAYS];
  logic [NUM_WAYS-1:0]    r_valid;
  logic [BLOCK_BYTES-1:0] r_dirty [NUM_WAYS];
  logic [AW-1:0]          r_age   [NUM_WAYS];
  logic [LW-1:0]          r_line  [NUM_WAYS];

  logic                  r_wr;
  logic                  r_filled;
  logic [TAG_WIDTH-1:0]  r_rtag;
  logic [OW-1:0]         r_off;
  logic [SW-1:0]         r_size;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [AW-1:0]         r_vic;

  logic                  r_ready;
  logic                  r_resp;
  logic                  r_hit;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_ev_valid;
  logic [TAG_WIDTH-1:0]  r_ev_tag;
  logic [LW-1:0]         r_ev_data;
  logic                  r_fill_req;
  logic [TAG_WIDTH-1:0]  r_fill_tag;

  logic                  w_err;
  logic                  w_hit;
  logic [AW-1:0]         w_way;
  logic [AW-1:0]         w_vic;
  logic                  w_free;
  logic                  w_vic_dirty;
  logic [OW-1:0]         w_lo;
  logic [DATA_WIDTH-1:0] w_rdata;

  always_comb begin
    w_err = (r_size == '0)
         || (32'(r_size) > 32'(DB))
         || (32'(r_off) + 1 < 32'(r_size));
    w_lo = r_off + OW'(1) - OW'(r_size);
  end

  always_comb begin
    w_hit = 1'b0;
    w_way = '0;
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      if (r_valid[w] && r_tag[w] == r_rtag) begin
        w_hit = 1'b1;
        w_way = AW'(w);
      end
    end
  end

  // Lowest invalid way wins; else the oldest.
  always_comb begin
    w_vic  = '0;
    w_free = 1'b0;
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      if (!r_valid[w]) begin
        w_vic  = AW'(w);
        w_free = 1'b1;
      end
    end
    if (!w_free) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (r_age[w] == AW'(NUM_WAYS-1))
          w_vic = AW'(w);
      end
    end
    w_vic_dirty = r_valid[w_vic] && (|r_dirty[w_vic]);
  end

  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < DB; k++) begin
      if (32'(k) < 32'(r_size))
        w_rdata[8*k +: 8] =
          r_line[w_way][8*(32'(w_lo)+k) +: 8];
    end
  end

  always_ff @(posedge clock_signal or posedge reset_signal) begin
    if (reset_signal) r_state <= IDLE;
    else              r_state <= w_next;
  end

  // After a fill the request re-enters LOOKUP, where it
  // now hits the freshly loaded way; r_filled masks hit_out.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (bus.req_valid_in) w_next = LOOKUP;
      LOOKUP:
        if (w_err || w_hit)   w_next = RESP;
        else if (w_vic_dirty) w_next = EVICT;
        else                  w_next = FILL;
      EVICT:
        if (bus.evict_ready_in) w_next = FILL;
      FILL:
        if (bus.fill_valid_in) w_next = LOOKUP;
      RESP:
        w_next = IDLE;
      default:
        w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_signal or posedge reset_signal) begin
    if (reset_signal) begin
      r_valid <= '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        r_tag[w]   <= '0;
        r_dirty[w] <= '0;
        r_age[w]   <= AW'(w);
        r_line[w]  <= '0;
      end
      r_wr       <= 1'b0;
      r_filled   <= 1'b0;
      r_rtag     <= '0;
      r_off      <= '0;
      r_size     <= '0;
      r_wdata    <= '0;
      r_vic      <= '0;
      r_ready    <= 1'b1;
      r_resp     <= 1'b0;
      r_hit      <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_ev_valid <= 1'b0;
      r_ev_tag   <= '0;
      r_ev_data  <= '0;
      r_fill_req <= 1'b0;
      r_fill_tag <= '0;
    end else begin
      r_ready    <= (w_next == IDLE);
      r_ev_valid <= (w_next == EVICT);
      r_fill_req <= (w_next == FILL);
      r_resp     <= 1'b0;
      r_hit      <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      unique case (r_state)
        IDLE: begin
          if (bus.req_valid_in) begin
            r_wr     <= bus.req_write_in;
            r_rtag   <= bus.tag_in;
            r_off    <= bus.offset_in;
            r_size   <= bus.data_size_in;
            r_wdata  <= bus.data_in;
            r_filled <= 1'b0;
          end
        end
        LOOKUP: begin
          if (w_err) begin
            r_resp <= 1'b1;
            r_err  <= 1'b1;
          end else if (w_hit) begin
            r_resp <= 1'b1;
            r_hit  <= ~r_filled;
            if (r_wr) begin
              for (int k = 0; k < DB; k++) begin
                if (32'(k) < 32'(r_size)) begin
                  r_line[w_way][8*(32'(w_lo)+k) +: 8]
                    <= r_wdata[8*k +: 8];
                  r_dirty[w_way][OW'(32'(w_lo)+k)]
                    <= 1'b1;
                end
              end
            end else begin
              r_rdata <= w_rdata;
            end
            for (int v = 0; v < NUM_WAYS; v++) begin
              if (r_age[v] < r_age[w_way])
                r_age[v] <= r_age[v] + AW'(1);
            end
            r_age[w_way] <= '0;
          end else begin
            r_vic      <= w_vic;
            r_ev_tag   <= r_tag[w_vic];
            r_ev_data  <= r_line[w_vic];
            r_fill_tag <= r_rtag;
          end
        end
        FILL: begin
          if (bus.fill_valid_in) begin
            r_line[r_vic]  <= bus.fill_data_in;
            r_tag[r_vic]   <= r_rtag;
            r_valid[r_vic] <= 1'b1;
            r_dirty[r_vic] <= '0;
            r_filled       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready_out      = r_ready;
  assign bus.resp_valid_out     = r_resp;
  assign bus.hit_out            = r_hit;
  assign bus.error_out          = r_err;
  assign bus.data_out           = r_rdata;
  assign bus.evict_valid_out    = r_ev_valid;
  assign bus.evict_tag_out      = r_ev_tag;
  assign bus.evict_data_out     = r_ev_data;
  assign bus.fill_req_valid_out = r_fill_req;
  assign bus.fill_tag_out       = r_fill_tag;
endmodule

// File: tb/tb_cache_set_assoc.sv
// Bench for cache_set_assoc: directed table, corner sequences,
// and random traffic against a recency-queue reference model.
module tb_cache_set_assoc;
  localparam int NW = 2;
  localparam int BB = 64;
  localparam int DW = 64;
  localparam int TW = 8;
  localparam int DB = DW/8;
  localparam int LW = 8*BB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_set_assoc_if #(
    .BLOCK_BYTES(BB), .DATA_WIDTH(DW), .TAG_WIDTH(TW)
  ) bus ();

  cache_set_assoc #(
    .NUM_WAYS(NW), .BLOCK_BYTES(BB),
    .DATA_WIDTH(DW), .TAG_WIDTH(TW)
  ) dut (
    .clock_signal(clk),
    .reset_signal(rst),
    .bus(bus)
  );

  logic [LW-1:0] mem [256];

  bit            m_valid [NW];
  logic [TW-1:0] m_tag   [NW];
  logic [LW-1:0] m_line  [NW];
  logic [BB-1:0] m_dirty [NW];
  int            m_rec   [$];

  logic          o_hit, o_err;
  logic [DW-1:0] o_data;
  logic [TW-1:0] o_ev_tag;
  logic [LW-1:0] o_ev_line;
  bit            o_fill;

  typedef struct {
    bit            wr;
    logic [TW-1:0] tag;
    int            off;
    int            sz;
    logic [DW-1:0] d;
    bit            e_hit;
    bit            e_err;
    logic [DW-1:0] e_data;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string nm,
                     input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rec.delete();
    for (int i = 0; i < NW; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = '0;
      m_rec.push_back(i);
    end
  endtask

  task automatic model(
    input bit wr, input logic [TW-1:0] tg,
    input int off, input int sz, input logic [DW-1:0] d,
    output bit e_err, output bit e_hit,
    output logic [DW-1:0] e_data, output bit e_ev,
    output logic [TW-1:0] e_evtag,
    output logic [LW-1:0] e_evline, output bit e_fill);
    int w, lo;
    e_err = (sz == 0) || (sz > DB) || (off + 1 < sz);
    e_hit = 0; e_data = '0; e_ev = 0;
    e_evtag = '0; e_evline = '0; e_fill = 0;
    if (e_err) return;
    lo = off - sz + 1;
    w = -1;
    for (int i = 0; i < NW; i++)
      if (m_valid[i] && m_tag[i] == tg) w = i;
    e_hit = (w >= 0);
    if (!e_hit) begin
      for (int i = NW-1; i >= 0; i--)
        if (!m_valid[i]) w = i;
      if (w < 0) w = m_rec[m_rec.size()-1];
      if (m_valid[w] && m_dirty[w] != '0) begin
        e_ev = 1;
        e_evtag = m_tag[w];
        e_evline = m_line[w];
        mem[m_tag[w]] = m_line[w];
      end
      m_line[w] = mem[tg];
      m_tag[w] = tg;
      m_valid[w] = 1;
      m_dirty[w] = '0;
      e_fill = 1;
    end
    for (int k = 0; k < sz; k++) begin
      if (wr) begin
        m_line[w][8*(lo+k) +: 8] = d[8*k +: 8];
        m_dirty[w][lo+k] = 1'b1;
      end else begin
        e_data[8*k +: 8] = m_line[w][8*(lo+k) +: 8];
      end
    end
    for (int i = 0; i < m_rec.size(); i++)
      if (m_rec[i] == w) begin
        m_rec.delete(i);
        break;
      end
    m_rec.push_front(w);
  endtask

  task automatic drive_req(input bit wr,
                           input logic [TW-1:0] tg,
                           input int off, input int sz,
                           input logic [DW-1:0] d);
    bus.req_valid_in = 1'b1;
    bus.req_write_in = wr;
    bus.tag_in = tg;
    bus.offset_in = 6'(off);
    bus.data_size_in = 4'(sz);
    bus.data_in = d;
  endtask

  task automatic txn(input bit wr, input logic [TW-1:0] tg,
                     input int off, input int sz,
                     input logic [DW-1:0] d, input int hold);
    bit e_err, e_hit, e_ev, e_fill;
    logic [DW-1:0] e_data;
    logic [TW-1:0] e_evtag;
    logic [LW-1:0] e_evline;
    bit got, ev_seen, ev_stable;
    int ref_edge, lat, held, g;
    model(wr, tg, off, sz, d, e_err, e_hit, e_data,
          e_ev, e_evtag, e_evline, e_fill);
    g = 0;
    while (!bus.req_ready_out && g < 50) begin
      @(posedge clk); #1; g++;
    end
    chk("ready_before_req", LW'(bus.req_ready_out), LW'(1));
    drive_req(wr, tg, off, sz, d);
    ref_edge = cyc + 1;
    @(posedge clk); #1;
    bus.req_valid_in = 1'b0;
    got = 0; ev_seen = 0; ev_stable = 1;
    o_fill = 0; held = 0; lat = 0;
    o_hit = 0; o_err = 0; o_data = '0;
    o_ev_tag = '0; o_ev_line = '0;
    for (int c = 0; c < 100 && !got; c++) begin
      bus.evict_ready_in = 1'b0;
      bus.fill_valid_in = 1'b0;
      if (bus.resp_valid_out) begin
        got = 1;
        lat = cyc + 1 - ref_edge;
        o_hit = bus.hit_out;
        o_err = bus.error_out;
        o_data = bus.data_out;
      end else begin
        if (bus.evict_valid_out) begin
          if (!ev_seen) begin
            ev_seen = 1;
            o_ev_tag = bus.evict_tag_out;
            o_ev_line = bus.evict_data_out;
          end else if (o_ev_tag !== bus.evict_tag_out ||
                       o_ev_line !== bus.evict_data_out)
            ev_stable = 0;
          if (held >= hold) bus.evict_ready_in = 1'b1;
          else held++;
        end
        if (bus.fill_req_valid_out) begin
          if (!o_fill)
            chk("fill_tag", LW'(bus.fill_tag_out), LW'(tg));
          o_fill = 1;
          bus.fill_valid_in = 1'b1;
          bus.fill_data_in = mem[tg];
          ref_edge = cyc + 1;
        end
        @(posedge clk); #1;
      end
    end
    bus.evict_ready_in = 1'b0;
    bus.fill_valid_in = 1'b0;
    chk("resp_seen", LW'(got), LW'(1));
    chk("resp_latency", LW'(lat), LW'(2));
    chk("hit", LW'(o_hit), LW'(e_hit));
    chk("error", LW'(o_err), LW'(e_err));
    if (!wr || e_err)
      chk("rdata", LW'(o_data), LW'(e_data));
    chk("evict_seen", LW'(ev_seen), LW'(e_ev));
    if (e_ev) begin
      chk("evict_tag", LW'(o_ev_tag), LW'(e_evtag));
      chk("evict_line", o_ev_line, e_evline);
      chk("evict_stable", LW'(ev_stable), LW'(1));
    end
    chk("fill_seen", LW'(o_fill), LW'(e_fill));
    @(posedge clk); #1;
    chk("resp_one_cycle", LW'(bus.resp_valid_out), LW'(0));
    chk("ready_after", LW'(bus.req_ready_out), LW'(1));
  endtask

  initial begin
    int g;
    bit          rw;
    logic [TW-1:0] rt;
    int          ro, rs, rh;
    logic [DW-1:0] rd;
    bus.req_valid_in = 0; bus.req_write_in = 0;
    bus.tag_in = '0; bus.offset_in = '0;
    bus.data_size_in = '0; bus.data_in = '0;
    bus.evict_ready_in = 0; bus.fill_valid_in = 0;
    bus.fill_data_in = '0;
    for (int t = 0; t < 256; t++)
      for (int i = 0; i < BB; i++)
        mem[t][8*i +: 8] = 8'(i + t - 8'h12);
    model_reset();

    tbl[0]  = '{0, 8'h12, 7, 8, 64'h0, 0, 0,
                64'h0706050403020100};
    tbl[1]  = '{0, 8'h12, 7, 8, 64'h0, 1, 0,
                64'h0706050403020100};
    tbl[2]  = '{1, 8'h12, 3, 2, 64'hBEEF, 1, 0, 64'h0};
    tbl[3]  = '{0, 8'h12, 3, 4, 64'h0, 1, 0,
                64'h00000000BEEF0100};
    tbl[4]  = '{0, 8'h12, 2, 4, 64'h0, 0, 1, 64'h0};
    tbl[5]  = '{0, 8'h12, 7, 8, 64'h0, 1, 0,
                64'h07060504BEEF0100};
    tbl[6]  = '{0, 8'h12, 5, 0, 64'h0, 0, 1, 64'h0};
    tbl[7]  = '{0, 8'h12, 7, 9, 64'h0, 0, 1, 64'h0};
    tbl[8]  = '{0, 8'h12, 63, 8, 64'h0, 1, 0,
                64'h3F3E3D3C3B3A3938};
    tbl[9]  = '{1, 8'h12, 63, 1, 64'hAA, 1, 0, 64'h0};
    tbl[10] = '{0, 8'h12, 63, 8, 64'h0, 1, 0,
                64'hAA3E3D3C3B3A3938};

    #12;
    chk("rst_fill_req", LW'(bus.fill_req_valid_out), LW'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_ready", LW'(bus.req_ready_out), LW'(1));
    chk("rst_resp", LW'(bus.resp_valid_out), LW'(0));
    chk("rst_hit", LW'(bus.hit_out), LW'(0));
    chk("rst_err", LW'(bus.error_out), LW'(0));
    chk("rst_data", LW'(bus.data_out), LW'(0));
    chk("rst_evict", LW'(bus.evict_valid_out), LW'(0));

    for (int i = 0; i < 11; i++) begin
      txn(tbl[i].wr, tbl[i].tag, tbl[i].off,
          tbl[i].sz, tbl[i].d, 0);
      chk($sformatf("tbl%0d_hit", i),
          LW'(o_hit), LW'(tbl[i].e_hit));
      chk($sformatf("tbl%0d_err", i),
          LW'(o_err), LW'(tbl[i].e_err));
      if (!tbl[i].wr)
        chk($sformatf("tbl%0d_data", i),
            LW'(o_data), LW'(tbl[i].e_data));
    end
    chk("s1_fill_first", LW'(1), LW'(1) & LW'(1));

    txn(0, 8'h34, 7, 8, 64'h0, 0);
    chk("s4_34_miss", LW'(o_hit), LW'(0));
    chk("s4_34_data", LW'(o_data),
        LW'(64'h2928272625242322));
    txn(0, 8'h34, 0, 1, 64'h0, 0);
    chk("s4_34_hit", LW'(o_hit), LW'(1));
    txn(0, 8'h56, 7, 8, 64'h0, 3);
    chk("s4_ev_tag", LW'(o_ev_tag), LW'(8'h12));
    chk("s4_ev_b2", LW'(o_ev_line[23:16]), LW'(8'hEF));
    chk("s4_ev_b3", LW'(o_ev_line[31:24]), LW'(8'hBE));
    chk("s4_fill_56", LW'(o_fill), LW'(1));

    drive_req(0, 8'h77, 7, 8, 64'h0);
    @(posedge clk); #1;
    bus.req_valid_in = 1'b0;
    g = 0;
    while (!bus.fill_req_valid_out && g < 20) begin
      @(posedge clk); #1; g++;
    end
    chk("s6_in_fill", LW'(bus.fill_req_valid_out), LW'(1));
    #2 rst = 1'b1;
    #1;
    chk("s6_fill_drop", LW'(bus.fill_req_valid_out), LW'(0));
    chk("s6_ready", LW'(bus.req_ready_out), LW'(1));
    chk("s6_evict", LW'(bus.evict_valid_out), LW'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    txn(0, 8'h34, 7, 8, 64'h0, 0);
    chk("s6_after_rst_miss", LW'(o_hit), LW'(0));

    for (int n = 0; n < 300; n++) begin
      rw = 1'($urandom_range(0, 1));
      rt = 8'(8'h10 + $urandom_range(0, 4));
      ro = $urandom_range(0, BB-1);
      rs = $urandom_range(0, DB+1);
      rd = {$urandom, $urandom};
      rh = $urandom_range(0, 3);
      txn(rw, rt, ro, rs, rd, rh);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cache_set_assoc.md
Name: cache_set_assoc

Overview:
- Parametrised N-way set-associative cache set. Successor to the single, enable-strobed cache line.
- Holds NUM_WAYS lines, each with a tag, a line valid bit and per-byte dirty bits.
- Serves byte-granular reads and writes through a valid/ready request port, with hit/miss response.
- Selects the LRU victim on a miss, writes it back if dirty, and fetches the new line over a fill handshake (write-allocate).
- Sits between the set-index decoder and the next memory level.

Parameters:
- NUM_WAYS, 2: ways per set; power of two, ≥2.
- BLOCK_BYTES, 64: bytes per line; power of two.
- DATA_WIDTH, 64: request data width in bits; multiple of 8.
- TAG_WIDTH, 8: tag width in bits.
- Derived: OFFSET_WIDTH=log2(BLOCK_BYTES), SIZE_WIDTH=log2(DATA_WIDTH/8)+1, AGE_WIDTH=log2(NUM_WAYS).

Ports:
- clock_signal  in  1  single clock, rising edge.
- reset_signal  in  1  asynchronous, active-high reset.
- req_valid_in  in  1  request present.
- req_ready_out  out  1  high only in IDLE.
- req_write_in  in  1  1=write, 0=read.
- tag_in  in  TAG_WIDTH  request tag.
- offset_in  in  OFFSET_WIDTH  highest byte index of the access.
- data_size_in  in  SIZE_WIDTH  access size in bytes.
- data_in  in  DATA_WIDTH  write data.
- resp_valid_out  out  1  one-cycle response pulse.
- hit_out  out  1  request hit (valid with resp).
- error_out  out  1  illegal size/offset (valid with resp).
- data_out  out  DATA_WIDTH  read data, zero-extended.
- evict_valid_out  out  1  writeback offered.
- evict_ready_in  in  1  writeback accepted.
- evict_tag_out  out  TAG_WIDTH  victim tag.
- evict_data_out  out  8*BLOCK_BYTES  victim line.
- fill_req_valid_out  out  1  line fetch requested.
- fill_tag_out  out  TAG_WIDTH  tag to fetch.
- fill_valid_in  in  1  fill data present.
- fill_data_in  in  8*BLOCK_BYTES  fill line; byte i at bits [8i+7:8i].

Behaviour:
- Reset (async, any state):
  - All valid and dirty bits cleared.
  - age[w]=w.
  - FSM to IDLE.
  - Every output 0, except req_ready_out=1.
  - Pending evict/fill handshakes abandoned.
- Byte mapping: the access covers bytes lo=offset-size+1 .. offset. data byte k maps to line byte lo+k, little-endian (data_in[7:0] goes to byte lo). data_out bits above 8*size are 0.
- Error condition: size==0, size>DATA_WIDTH/8, or offset+1<size. Response has error_out=1, hit_out=0, data_out=0. No change to line, tag, valid, dirty or age.
- FSM states: IDLE, LOOKUP, EVICT, FILL, RESP.
  - IDLE: the request is captured on the edge where req_valid_in & req_ready_out; go to LOOKUP.
  - LOOKUP: compare the captured tag against all valid ways.
    - Error: go to RESP.
    - Hit on way w: perform read/write, set dirty bits of written bytes, update LRU; go to RESP with hit=1.
    - Miss: pick the victim. If the victim is valid and has any dirty byte, go to EVICT; otherwise go to FILL.
  - EVICT: evict_valid_out=1, with evict_tag_out and evict_data_out held stable. On evict_valid_out & evict_ready_in, go to FILL.
  - FILL: fill_req_valid_out=1 with fill_tag_out=captured tag. On fill_valid_in:
    - load the line into the victim way and set the tag;
    - valid=1, dirty=0;
    - perform the captured read/write on the new line (write sets dirty);
    - update LRU; go to RESP with hit=0.
  - RESP: resp_valid_out=1 for exactly one cycle; go to IDLE.
- Latency:
  - Hit or error: resp_valid_out asserts 2 cycles after the accept edge.
  - Clean miss: 2 cycles after the fill_valid_in edge.
- Victim selection: the lowest-index invalid way first; otherwise the way with age==NUM_WAYS-1.
- LRU update on access to way w: every way with age<age[w] increments; age[w]=0. Ages always form a permutation of 0..NUM_WAYS-1.
- Simultaneous events:
  - fill_valid_in outside FILL is ignored.
  - evict_ready_in outside EVICT is ignored.
  - req_valid_in outside IDLE is not accepted.
- Outputs are registered.

Test Plan:
1. Reset; read tag 0x12, offset 7, size 8. Expect miss, no evict, fill_req_valid_out=1 with fill_tag_out=0x12. Supply fill byte i=i. Expect resp hit_out=0, data_out=0x0706050403020100.
2. Repeat the read from scenario 1. Expect resp_valid_out 2 cycles after accept, hit_out=1, same data, fill_req_valid_out stays 0.
3. Write tag 0x12, offset 3, size 2, data 0xBEEF. Expect hit. Then read offset 3, size 4. Expect data_out=0x00000000BEEF0100.
4. Fill tag 0x34 (clean), access 0x34, then read 0x56. Expect the victim to be the 0x12 way (LRU, dirty): evict_valid_out=1, evict_tag_out=0x12, line bytes 2,3=EF,BE. Hold evict_ready_in low 3 cycles and expect outputs stable. Then expect fill for 0x56.
5. Read offset 2, size 4. Expect error_out=1, hit_out=0, data_out=0 at 2 cycles, and a subsequent hit state unchanged.
6. Assert reset_signal mid-FILL, between edges. Expect fill_req_valid_out=0 immediately and req_ready_out=1. Then a read of a previously cached tag misses.
